// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit carry-look-ahead slice per clock, LSB nibble first.
// Latency: out_valid rises NIBBLES clocks after the accept edge.
// Backpressure: result held in DONE until out_ready; new operands refused until back in IDLE.

module nand_gate #(parameter int N = 2) (
    input  logic [N-1:0] a,
    output logic         y
);
    assign y = ~&a;
endmodule

module and_gate #(parameter int N = 2) (
    input  logic [N-1:0] a,
    output logic         y
);
    logic n;
    nand_gate #(.N(N)) u_nand (.a(a), .y(n));
    nand_gate #(.N(1)) u_inv  (.a(n), .y(y));
endmodule

module or_gate #(parameter int N = 2) (
    input  logic [N-1:0] a,
    output logic         y
);
    logic [N-1:0] na;
    for (genvar i = 0; i < N; i++) begin : g_inv
        nand_gate #(.N(1)) u_inv (.a(a[i]), .y(na[i]));
    end
    nand_gate #(.N(N)) u_nand (.a(na), .y(y));
endmodule

module xor_gate (
    input  logic [1:0] a,
    output logic       y
);
    logic n0, n1, n2;
    nand_gate #(.N(2)) u_n0 (.a(a),           .y(n0));
    nand_gate #(.N(2)) u_n1 (.a({a[0], n0}),  .y(n1));
    nand_gate #(.N(2)) u_n2 (.a({a[1], n0}),  .y(n2));
    nand_gate #(.N(2)) u_n3 (.a({n1, n2}),    .y(y));
endmodule

module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       cout
);
    logic [3:0] p, g;
    logic [4:0] c;
    logic [4:0] gx;

    assign c[0] = cin;
    assign gx   = {g, cin};

    for (genvar i = 0; i < 4; i++) begin : g_bit
        xor_gate            u_p (.a({a[i], b[i]}), .y(p[i]));
        and_gate #(.N(2))   u_g (.a({a[i], b[i]}), .y(g[i]));
        xor_gate            u_s (.a({p[i], c[i]}), .y(s[i]));

        // c[i+1] = OR over k of (g[k-1] or cin) propagated through p[i:k]
        logic [i+1:0] t;
        for (genvar k = 0; k <= i + 1; k++) begin : g_term
            if (k == i + 1) begin : g_gen
                and_gate #(.N(1)) u_t (.a(gx[k]), .y(t[k]));
            end else begin : g_prop
                and_gate #(.N(i - k + 2)) u_t (.a({p[i:k], gx[k]}), .y(t[k]));
            end
        end
        or_gate #(.N(i + 2)) u_c (.a(t), .y(c[i+1]));
    end

    assign c3   = c[3];
    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, psum, psum_next;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [3:0]       slice_s;
    logic             slice_c3, slice_c4, last;

    cla4_slice u_slice (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .c3   (slice_c3),
        .cout (slice_c4)
    );

    if (WIDTH == 4) begin : g_one_nibble
        assign psum_next = slice_s;
    end else begin : g_multi_nibble
        assign psum_next = {slice_s, psum[WIDTH-1:4]};
    end

    assign last      = (cnt == CW'(NIBBLES - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            psum     <= '0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    psum    <= psum_next;
                    carry_q <= slice_c4;
                    if (last) begin
                        // Final nibble: its carry-in to bit 3 is the carry into the MSB
                        sum      <= psum_next;
                        cout     <= slice_c4;
                        overflow <= slice_c3 ^ slice_c4;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder against an arithmetic reference.
module tb_nibble_serial_adder;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally stall the consumer (driving junk operands meanwhile).
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input int stall, input bit junk);
        logic [W:0]   full;
        logic         ovf;
        int           cyc;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);

        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        a = x; b = y; cin = c; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);

        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (out_valid) break;
            chk("in_ready_busy", in_ready, 0);
        end
        chk("latency", cyc, NIB);
        chk("in_ready_done", in_ready, 0);
        chk("sum", sum, full[W-1:0]);
        chk("cout", cout, full[W]);
        chk("overflow", overflow, ovf);

        for (int i = 0; i < stall; i++) begin
            if (junk) begin
                in_valid = 1'b1;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_ready", in_ready, 0);
            chk("stall_sum", sum, full[W-1:0]);
            chk("stall_cout", cout, full[W]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("drain_valid", out_valid, 0);
        chk("drain_ready", in_ready, 1);
        chk("held_sum", sum, full[W-1:0]);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);

        // Asynchronous reset asserted mid-cycle
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        chk("arst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);

        // Backpressure with new operands offered while DONE, then a clean follow-up
        run_op(16'h2468, 16'h1357, 1'b1, 6, 1'b1);
        run_op(16'h0F00, 16'h00F0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Reset after two RUN cycles discards the operation
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_stale_valid", out_valid, 0);
        end
        run_op(16'h0F0F, 16'hF0F1, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle adder that adds two WIDTH-bit operands 4 bits per clock through one internal 4-bit carry-look-ahead slice.
- The slice is built only from the team's NAND-based xor_gate/and_gate/or_gate primitives.
- A carry register links successive nibbles, and an FSM with a valid/ready handshake on each side sequences the operation.
- Sits between the operand source and the result consumer. This is the sequential stage that drives the 4-bit CLA datapath.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived local constant; number of slice passes. Not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  A+B+cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- overflow  output  1  two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, nibble counter=0, carry reg=0, operand shift regs=0.
- On rst_n deassertion the block resumes at IDLE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are registered-state decodes with no combinational input-to-output path.
- IDLE: on in_valid&&in_ready at edge T0:
  - capture a, b into shift regs and cin into the carry reg;
  - counter=0;
  - go to RUN.
- RUN, each cycle:
  - slice adds the low nibbles of the shift regs plus the carry reg;
  - at the edge, the 4-bit result shifts into the top of the partial-sum reg (LSB nibble first);
  - the slice carry-out loads the carry reg;
  - the operand shift regs shift right by 4;
  - counter increments.
  - Carry into bit 3 of the current nibble is recorded every cycle; only the last nibble's value is used.
- After the NIBBLES-th slice pass (counter==NIBBLES-1 at the edge), the edge:
  - loads sum from the partial-sum reg (including the final nibble);
  - loads cout from the final slice carry;
  - loads overflow = carry into MSB XOR carry out of MSB;
  - moves the FSM to DONE.
- Latency: out_valid rises exactly NIBBLES clocks after the accept edge (4 for WIDTH=16; 1 for WIDTH=4).
- DONE: sum/cout/overflow are held stable while out_ready is low. On out_valid&&out_ready, go to IDLE at that edge. in_ready rises the following cycle; same-cycle result-drain plus new accept is not supported.
- Outputs sum/cout/overflow change only on the DONE-entry edge. They keep the last result in IDLE and RUN and are reset only by rst_n.
- in_valid, a, b and cin are ignored outside IDLE. Operand changes during RUN do not affect the result.
- Simultaneous in_valid and reset: reset wins and nothing is captured.
- Reset mid-RUN or mid-DONE: the operation is discarded, out_valid goes low immediately (asynchronously), and no partial result ever appears.
- Arithmetic: the full result is the WIDTH+1-bit sum {cout,sum} = a+b+cin, unsigned, exact. There is no saturation.
- Counter width is clog2(NIBBLES), minimum 1 bit. The counter never wraps past NIBBLES-1 in RUN.

Test Plan:
- Reset check: assert rst_n low mid-cycle -> immediately in_ready=1, out_valid=0, sum=16'h0000, cout=0, overflow=0.
- 16'h1234 + 16'h4321, cin=0 -> after exactly 4 clocks out_valid=1, sum=16'h5555, cout=0, overflow=0; in_ready=0 for those 4 cycles.
- 16'hFFFF + 16'h0001, cin=0 -> sum=16'h0000, cout=1, overflow=0 (carry ripples through all nibbles). Then 16'hFFFF + 16'h0000 with cin=1 -> identical result.
- 16'h7FFF + 16'h0001 -> sum=16'h8000, cout=0, overflow=1. 16'h8000 + 16'h8000 -> sum=16'h0000, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while driving in_valid=1 with new operands -> out_valid stays 1, sum is stable, in_ready=0 and nothing is captured. Raise out_ready -> IDLE next edge, in_ready=1 the cycle after, and the next operation completes correctly.
- Reset after 2 RUN cycles of 16'hABCD + 16'h1111 -> out_valid never asserts and in_ready=1. A following 16'h0F0F + 16'hF0F1 gives sum=16'h0000, cout=1, overflow=0.
